branch_resolve_sequencer: RTL and testbench
===========================================

Name: branch_resolve_sequencer

Overview:
- Sequences training and recovery around the bimodal 2-bit branch predictor.
- Keeps an in-order queue of in-flight predicted branches from ID.
- When each branch resolves in MEM, it pops the matching record, issues a one-cycle registered counter-update command to the predictor, and on a mispredict raises a flush with the correct redirect PC.
- Sits between the ID/MEM pipeline control and the predictor's pattern table. It also keeps branch and mispredict statistics.

Parameters:
- TABLE_BITS, 1, width of the predictor table index carried per entry.
- DEPTH_BITS, 2, log2 of queue depth. DEPTH = 1<<DEPTH_BITS in-flight branches.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  branch decoded in ID this cycle, with prediction made.
- dec_index  in  TABLE_BITS  predictor table index used for the prediction.
- dec_pred  in  1  predicted direction, 1 = taken.
- dec_pc  in  32  PC of the branch.
- dec_target  in  32  computed taken target.
- res_valid  in  1  oldest in-flight branch resolves in MEM this cycle.
- res_taken  in  1  actual outcome.
- full  out  1  queue holds DEPTH entries. ID must stall branches.
- empty  out  1  queue holds 0 entries.
- upd_valid  out  1  predictor counter-update strobe.
- upd_index  out  TABLE_BITS  entry to update.
- upd_taken  out  1  actual outcome to train with.
- flush  out  1  mispredict. Squash IF/ID/EX and redirect.
- redirect_pc  out  32  correct next PC, valid when flush=1.
- br_count  out  CNT_WIDTH  resolved branches, saturating.
- mp_count  out  CNT_WIDTH  mispredicts, saturating.
- underflow  out  1  sticky error: res_valid seen with empty queue.

Behaviour:

Reset (asynchronous, rst_n=0):
- Queue pointers and count are cleared, so empty=1 and full=0.
- upd_valid, flush, underflow, br_count and mp_count are 0.
- upd_index and redirect_pc are 0.
- Reset asserted mid-operation discards all entries immediately. Nothing is emitted after release.

Queue:
- Circular FIFO of DEPTH records {index, pred, pc, target}.
- Write and read pointers are DEPTH_BITS wide and wrap modulo DEPTH.
- Count is DEPTH_BITS+1 wide.
- full and empty are derived combinationally from the registered count.

Push:
- A push occurs when dec_valid=1 and (count<DEPTH or pop this cycle), and no mispredict is being resolved this cycle.
- dec_valid while full with no pop: the record is dropped. ID is required to stall; no error is raised.

Pop:
- A pop occurs when res_valid=1 and count>0. It reads the head entry combinationally.
- res_valid with count=0: no pop, no upd_valid, no flush, no counter change. underflow is set and stays set until reset.

Simultaneous push and pop, correct prediction:
- Count is unchanged and both pointers advance.
- This is legal at full and at count=1.

Update (1-cycle latency):
- upd_valid is registered high the cycle after each pop.
- That cycle also carries upd_index = head.index and upd_taken = res_taken.
- upd_valid is a single-cycle pulse per pop. Back-to-back pops give back-to-back pulses.

Mispredict:
- A mispredict is a pop with head.pred != res_taken.
- At that clock edge:
  - The whole queue is cleared, because all younger entries are wrong-path.
  - Any simultaneous dec_valid is discarded.
  - flush is registered high for exactly one cycle.
  - redirect_pc = res_taken ? head.target : head.pc + 4, with the addition modulo 2^32.
- The update pulse for the mispredicted branch is still emitted in the same cycle as flush.

Statistics:
- br_count increments on every pop.
- mp_count increments on every mispredict pop.
- Both hold at all-ones rather than wrapping.

Test Plan:
1. Reset, then push 2 branches (idx 0 pred 0; idx 1 pred 1) and resolve both matching → upd_valid pulses for idx 0/taken 0, then idx 1/taken 1, each 1 cycle after res_valid. flush stays 0. br_count=2, mp_count=0, empty=1.
2. Push 4 branches with DEPTH_BITS=2 → full=1. A 5th dec_valid is dropped. Then push and resolve in the same cycle while full → count stays 4, pointers wrap, FIFO order is preserved across the wrap.
3. Push pc=0x100, target=0x80, pred=0 plus 2 younger branches; resolve taken → next cycle flush=1 and redirect_pc=0x80, upd_valid=1 with upd_taken=1. empty=1, mp_count=1. A dec_valid in the resolve cycle is discarded.
4. Predicted taken, actual not taken at pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap).
5. res_valid with empty queue → underflow=1 and sticky, no upd_valid, no flush, counters unchanged.
6. Pull rst_n low asynchronously with 3 entries queued and a pending flush → flush, upd_valid and counters drop to 0 immediately. No stale pulse after release.

Source files
------------

// File: rtl/branch_resolve_sequencer_if.sv
// rtl/branch_resolve_sequencer_if.sv - ID/MEM/predictor signal bundle for the branch resolve sequencer
interface branch_resolve_sequencer_if #(
  parameter int TABLE_BITS = 1,
  parameter int CNT_WIDTH  = 16
);
  logic                  dec_valid;
  logic [TABLE_BITS-1:0] dec_index;
  logic                  dec_pred;
  logic [31:0]           dec_pc;
  logic [31:0]           dec_target;
  logic                  res_valid;
  logic                  res_taken;
  logic                  full;
  logic                  empty;
  logic                  upd_valid;
  logic [TABLE_BITS-1:0] upd_index;
  logic                  upd_taken;
  logic                  flush;
  logic [31:0]           redirect_pc;
  logic [CNT_WIDTH-1:0]  br_count;
  logic [CNT_WIDTH-1:0]  mp_count;
  logic                  underflow;

  modport master (
    output dec_valid, dec_index, dec_pred, dec_pc, dec_target, res_valid, res_taken,
    input  full, empty, upd_valid, upd_index, upd_taken, flush, redirect_pc,
    input  br_count, mp_count, underflow
  );

  modport slave (
    input  dec_valid, dec_index, dec_pred, dec_pc, dec_target, res_valid, res_taken,
    output full, empty, upd_valid, upd_index, upd_taken, flush, redirect_pc,
    output br_count, mp_count, underflow
  );
endinterface

// File: rtl/branch_resolve_sequencer.sv
// rtl/branch_resolve_sequencer.sv - in-order branch queue driving predictor training and mispredict flush
module branch_resolve_sequencer #(
  parameter int TABLE_BITS = 1,
  parameter int DEPTH_BITS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  branch_resolve_sequencer_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [TABLE_BITS-1:0] idx_mem [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [31:0]           pc_mem [DEPTH];
  logic [31:0]           tgt_mem [DEPTH];

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [TABLE_BITS-1:0] upd_index_q, upd_index_d;
  logic                  flush_q, flush_d, underflow_q, underflow_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0]  br_count_q, br_count_d, mp_count_q, mp_count_d;

  logic pop, push, mispredict;
  logic [TABLE_BITS-1:0] head_index;
  logic                  head_pred;
  logic [31:0]           head_pc, head_target;

  assign head_index  = idx_mem[rd_ptr_q];
  assign head_pred   = pred_mem[rd_ptr_q];
  assign head_pc     = pc_mem[rd_ptr_q];
  assign head_target = tgt_mem[rd_ptr_q];

  assign pop        = bus.res_valid && (count_q != '0);
  assign mispredict = pop && (head_pred != bus.res_taken);
  // Anything decoded alongside a mispredict is younger than it, hence wrong-path.
  assign push       = bus.dec_valid && ((count_q != FULL_CNT) || pop) && !mispredict;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    upd_valid_d   = pop;
    upd_index_d   = upd_index_q;
    upd_taken_d   = upd_taken_q;
    flush_d       = mispredict;
    redirect_pc_d = redirect_pc_q;
    underflow_d   = underflow_q | (bus.res_valid && (count_q == '0));
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;

    if (pop) begin
      upd_index_d = head_index;
      upd_taken_d = bus.res_taken;
      if (br_count_q != '1) br_count_d = br_count_q + CNT_WIDTH'(1);
    end

    if (mispredict) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      redirect_pc_d = bus.res_taken ? head_target : head_pc + 32'd4;
      if (mp_count_q != '1) mp_count_d = mp_count_q + CNT_WIDTH'(1);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
      if (push && !pop)      count_d = count_q + (DEPTH_BITS + 1)'(1);
      else if (pop && !push) count_d = count_q - (DEPTH_BITS + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_q]  <= bus.dec_index;
      pred_mem[wr_ptr_q] <= bus.dec_pred;
      pc_mem[wr_ptr_q]   <= bus.dec_pc;
      tgt_mem[wr_ptr_q]  <= bus.dec_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      underflow_q   <= 1'b0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_taken_q   <= upd_taken_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      underflow_q   <= underflow_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  assign bus.full        = (count_q == FULL_CNT);
  assign bus.empty       = (count_q == '0);
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.br_count    = br_count_q;
  assign bus.mp_count    = mp_count_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_branch_resolve_sequencer.sv
// tb/tb_branch_resolve_sequencer.sv - directed self-checking bench for branch_resolve_sequencer
module tb_branch_resolve_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_sequencer_if #(.TABLE_BITS(1), .CNT_WIDTH(16)) bus ();

  branch_resolve_sequencer #(.TABLE_BITS(1), .DEPTH_BITS(2), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic idx, input logic pred,
                     input logic [31:0] pc, input logic [31:0] tgt);
    bus.dec_valid  = v;
    bus.dec_index  = idx;
    bus.dec_pred   = pred;
    bus.dec_pc     = pc;
    bus.dec_target = tgt;
  endtask

  task automatic res(input logic v, input logic taken);
    bus.res_valid = v;
    bus.res_taken = taken;
  endtask

  task automatic check_upd(input string tag, input logic v, input logic idx,
                           input logic taken, input logic fl);
    check({tag, "_upd_valid"}, 32'(bus.upd_valid), 32'(v));
    if (v) begin
      check({tag, "_upd_index"}, 32'(bus.upd_index), 32'(idx));
      check({tag, "_upd_taken"}, 32'(bus.upd_taken), 32'(taken));
    end
    check({tag, "_flush"}, 32'(bus.flush), 32'(fl));
  endtask

  initial begin
    dec(0, 0, 0, 0, 0);
    res(0, 0);
    #12;
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check_upd("rst", 0, 0, 0, 0);
    check("rst_br", 32'(bus.br_count), 0);
    check("rst_mp", 32'(bus.mp_count), 0);
    check("rst_uf", 32'(bus.underflow), 0);
    check("rst_upd_index", 32'(bus.upd_index), 0);
    check("rst_redirect", bus.redirect_pc, 0);
    rst_n = 1'b1;
    tick();

    // 1: two correctly predicted branches
    dec(1, 0, 0, 32'h10, 32'h20); tick();
    dec(1, 1, 1, 32'h14, 32'h40); tick();
    dec(0, 0, 0, 0, 0);
    check("t1_not_empty", 32'(bus.empty), 0);
    res(1, 0); tick();
    check_upd("t1_a", 1, 0, 0, 0);
    res(1, 1); tick();
    check_upd("t1_b", 1, 1, 1, 0);
    res(0, 0); tick();
    check_upd("t1_idle", 0, 0, 0, 0);
    check("t1_br", 32'(bus.br_count), 2);
    check("t1_mp", 32'(bus.mp_count), 0);
    check("t1_empty", 32'(bus.empty), 1);

    // 2: fill, drop when full, push+pop at full, drain across wrap
    dec(1, 0, 0, 32'h200, 32'h300); tick();
    dec(1, 1, 1, 32'h204, 32'h304); tick();
    dec(1, 1, 0, 32'h208, 32'h308); tick();
    dec(1, 0, 1, 32'h20C, 32'h30C); tick();
    check("t2_full", 32'(bus.full), 1);
    dec(1, 0, 0, 32'h210, 32'h310); tick();
    check("t2_full_drop", 32'(bus.full), 1);
    dec(1, 1, 1, 32'h214, 32'h314); res(1, 0); tick();
    dec(0, 0, 0, 0, 0);
    check("t2_full_pp", 32'(bus.full), 1);
    check_upd("t2_pp", 1, 0, 0, 0);
    res(1, 1); tick(); check_upd("t2_d1", 1, 1, 1, 0);
    res(1, 0); tick(); check_upd("t2_d2", 1, 1, 0, 0);
    res(1, 1); tick(); check_upd("t2_d3", 1, 0, 1, 0);
    res(1, 1); tick(); check_upd("t2_d4", 1, 1, 1, 0);
    res(0, 0);
    check("t2_empty", 32'(bus.empty), 1);
    check("t2_br", 32'(bus.br_count), 7);
    check("t2_mp", 32'(bus.mp_count), 0);

    // 3: mispredict taken, younger entries and concurrent decode discarded
    dec(1, 1, 0, 32'h100, 32'h80); tick();
    dec(1, 0, 0, 32'h104, 32'h180); tick();
    dec(1, 0, 1, 32'h108, 32'h280); tick();
    dec(1, 1, 1, 32'h10C, 32'h380); res(1, 1); tick();
    dec(0, 0, 0, 0, 0); res(0, 0);
    check_upd("t3_mp", 1, 1, 1, 1);
    check("t3_redirect", bus.redirect_pc, 32'h80);
    check("t3_empty", 32'(bus.empty), 1);
    check("t3_mp", 32'(bus.mp_count), 1);
    check("t3_br", 32'(bus.br_count), 8);
    tick();
    check_upd("t3_after", 0, 0, 0, 0);
    check("t3_dec_dropped", 32'(bus.empty), 1);

    // 4: not-taken redirect wraps past 2^32
    dec(1, 0, 1, 32'hFFFFFFFC, 32'h1234); tick();
    dec(0, 0, 0, 0, 0); res(1, 0); tick();
    res(0, 0);
    check_upd("t4_mp", 1, 0, 0, 1);
    check("t4_redirect", bus.redirect_pc, 32'h0);
    check("t4_mp", 32'(bus.mp_count), 2);
    tick();

    // 5: resolve with empty queue
    res(1, 1); tick();
    res(0, 0);
    check("t5_uf", 32'(bus.underflow), 1);
    check_upd("t5", 0, 0, 0, 0);
    check("t5_br", 32'(bus.br_count), 9);
    check("t5_mp", 32'(bus.mp_count), 2);
    tick(); tick();
    check("t5_uf_sticky", 32'(bus.underflow), 1);

    // 6a: async reset during a pending flush
    dec(1, 1, 0, 32'h400, 32'h500); tick();
    dec(0, 0, 0, 0, 0); res(1, 1); tick();
    res(0, 0);
    check("t6_flush_pre", 32'(bus.flush), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_flush_rst", 32'(bus.flush), 0);
    check("t6_upd_rst", 32'(bus.upd_valid), 0);
    check("t6_redirect_rst", bus.redirect_pc, 0);
    check("t6_mp_rst", 32'(bus.mp_count), 0);
    check("t6_uf_rst", 32'(bus.underflow), 0);
    #3 rst_n = 1'b1;
    tick();
    check_upd("t6_release", 0, 0, 0, 0);

    // 6b: async reset with three entries queued and an update pulse pending
    dec(1, 1, 1, 32'h600, 32'h700); tick();
    dec(1, 0, 0, 32'h604, 32'h704); tick();
    dec(1, 1, 0, 32'h608, 32'h708); tick();
    dec(1, 0, 1, 32'h60C, 32'h70C); tick();
    dec(0, 0, 0, 0, 0); res(1, 1); tick();
    res(0, 0);
    check("t6b_upd_pre", 32'(bus.upd_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6b_upd_rst", 32'(bus.upd_valid), 0);
    check("t6b_empty_rst", 32'(bus.empty), 1);
    check("t6b_br_rst", 32'(bus.br_count), 0);
    #3 rst_n = 1'b1;
    tick();
    check_upd("t6b_release", 0, 0, 0, 0);
    tick();
    check("t6b_empty_post", 32'(bus.empty), 1);
    check("t6b_br_post", 32'(bus.br_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
